// File: rtl/axil_read_arbiter.sv
// Purpose : shares one AXI-Lite read channel between instruction fetch and data load.
// Latency : Valid is high 3 cycles after the request is sampled in S_IDLE, plus one cycle per AR/R stall.
// Backpress: one transaction at a time; requests are level signals held until Valid, and slave stalls hold the FSM.
//
// Ports:
//   i_Clock, i_Reset_n                  clock (rising edge), async active-low reset
//   i_Instr_Req/Addr, o_Instr_Data/Valid fetch requester (level req, 1-cycle valid pulse)
//   i_Data_Req/Addr,  o_Data_Rdata/Valid load requester  (level req, 1-cycle valid pulse)
//   o_axil_ar*, i_axil_arready          AXI-Lite read address channel
//   i_axil_r*,  o_axil_rready           AXI-Lite read data channel
//   o_Busy                              high whenever the FSM is not idle
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
//   otherwise data has fixed priority over instr.
module axil_read_arbiter #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_n,
   input  logic                  i_Instr_Req,
   input  logic [XLEN-1:0]       i_Instr_Addr,
   output logic [DATA_WIDTH-1:0] o_Instr_Data,
   output logic                  o_Instr_Valid,
   input  logic                  i_Data_Req,
   input  logic [XLEN-1:0]       i_Data_Addr,
   output logic [DATA_WIDTH-1:0] o_Data_Rdata,
   output logic                  o_Data_Valid,
   output logic [ADDR_WIDTH-1:0] o_axil_araddr,
   output logic                  o_axil_arvalid,
   input  logic                  i_axil_arready,
   input  logic [DATA_WIDTH-1:0] i_axil_rdata,
   input  logic                  i_axil_rvalid,
   output logic                  o_axil_rready,
   output logic                  o_Busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AR   = 2'd1;
   localparam logic [1:0] S_R    = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            state_q;
   logic                  grant_data_q;   // 1: data port owns the transaction
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  any_req;
   logic                  pick_data;

   assign any_req = i_Instr_Req | i_Data_Req;

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers who won last; resets to DATA so the first tie goes to instr.
   logic last_data_q;

   assign pick_data = i_Data_Req & (~i_Instr_Req | ~last_data_q);

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         last_data_q <= 1'b1;
      end else if (state_q == S_IDLE && any_req) begin
         last_data_q <= pick_data;
      end
   end
`else
   // Fixed priority: a load always beats a fetch.
   assign pick_data = i_Data_Req;
`endif

   // Only the low ADDR_WIDTH bits reach the bus; upper address bits are dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_Instr_Addr, i_Data_Addr};

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q      <= S_IDLE;
         grant_data_q <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  grant_data_q <= pick_data;
                  addr_q       <= pick_data ? i_Data_Addr[ADDR_WIDTH-1:0]
                                            : i_Instr_Addr[ADDR_WIDTH-1:0];
                  state_q      <= S_AR;
               end
            end
            S_AR: begin
               if (i_axil_arready) begin
                  state_q <= S_R;
               end
            end
            S_R: begin
               if (i_axil_rvalid) begin
                  data_q  <= i_axil_rdata;
                  state_q <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from state so reset clears them in the same cycle.
   assign o_axil_arvalid = (state_q == S_AR);
   assign o_axil_araddr  = (state_q == S_AR) ? addr_q : '0;
   assign o_axil_rready  = (state_q == S_R);
   assign o_Busy         = (state_q != S_IDLE);
   assign o_Instr_Valid  = (state_q == S_DONE) & ~grant_data_q;
   assign o_Data_Valid   = (state_q == S_DONE) &  grant_data_q;
   assign o_Instr_Data   = o_Instr_Valid ? data_q : '0;
   assign o_Data_Rdata   = o_Data_Valid  ? data_q : '0;

endmodule

// File: tb/tb_axil_read_arbiter.sv
module tb_axil_read_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req, data_req;
   logic [31:0] instr_addr, data_addr;
   logic [31:0] instr_data, data_rdata;
   logic        instr_valid, data_valid;
   logic [15:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic        rvalid, rready, busy;

   int checks = 0;
   int errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
   logic model_last_data = 1'b1;
`endif

   always #5 clk = ~clk;

   axil_read_arbiter #(.XLEN(32), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .i_Clock        (clk),
      .i_Reset_n      (rst_n),
      .i_Instr_Req    (instr_req),
      .i_Instr_Addr   (instr_addr),
      .o_Instr_Data   (instr_data),
      .o_Instr_Valid  (instr_valid),
      .i_Data_Req     (data_req),
      .i_Data_Addr    (data_addr),
      .o_Data_Rdata   (data_rdata),
      .o_Data_Valid   (data_valid),
      .o_axil_araddr  (araddr),
      .o_axil_arvalid (arvalid),
      .i_axil_arready (arready),
      .i_axil_rdata   (rdata),
      .i_axil_rvalid  (rvalid),
      .o_axil_rready  (rready),
      .o_Busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Arbitration rule: a lone request wins; a tie goes to data (fixed) or
   // to whichever port did not win last (round robin).
   function automatic logic model_pick_data(input logic ireq, input logic dreq);
`ifdef ARB_ROUND_ROBIN_EN
      if (ireq && dreq) return !model_last_data;
`endif
      return dreq;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},    {31'd0, busy},        32'd0);
      check({tag, "_arvalid"}, {31'd0, arvalid},     32'd0);
      check({tag, "_araddr"},  {16'd0, araddr},      32'd0);
      check({tag, "_rready"},  {31'd0, rready},      32'd0);
      check({tag, "_ivld"},    {31'd0, instr_valid}, 32'd0);
      check({tag, "_dvld"},    {31'd0, data_valid},  32'd0);
      check({tag, "_idata"},   instr_data,           32'd0);
      check({tag, "_ddata"},   data_rdata,           32'd0);
   endtask

   // Called at a negedge with the DUT idle and requests already driven.
   // The transaction occupies cycles 1..lat after the sampling cycle; AR
   // takes a_st+1 cycles, R takes r_st+1 cycles, then one DONE cycle.
   task automatic do_txn(input int a_st, input int r_st, input logic [31:0] rd,
                         input bit scramble, output logic won_data);
      logic        wd;
      logic [15:0] ea;
      int          lat;
      bit          in_ar, in_r, done;
      wd = model_pick_data(instr_req, data_req);
      ea = wd ? data_addr[15:0] : instr_addr[15:0];
`ifdef ARB_ROUND_ROBIN_EN
      model_last_data = wd;
`endif
      lat = 3 + a_st + r_st;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         in_ar = (c <= a_st + 1);
         in_r  = (c > a_st + 1) && (c < lat);
         done  = (c == lat);
         check("arvalid", {31'd0, arvalid}, {31'd0, in_ar});
         check("araddr",  {16'd0, araddr},  in_ar ? {16'd0, ea} : 32'd0);
         check("rready",  {31'd0, rready},  {31'd0, in_r});
         check("busy",    {31'd0, busy},    32'd1);
         check("instr_valid", {31'd0, instr_valid}, {31'd0, done && !wd});
         check("instr_data",  instr_data, (done && !wd) ? rd : 32'd0);
         check("data_valid",  {31'd0, data_valid},  {31'd0, done && wd});
         check("data_rdata",  data_rdata, (done && wd) ? rd : 32'd0);
         arready = in_ar && (c == a_st + 1);
         rvalid  = in_r && (c == lat - 1);
         rdata   = rvalid ? rd : $urandom;
         if (scramble && !done) begin
            instr_addr = $urandom;
            data_addr  = $urandom;
         end
         if (done) begin
            if (wd) data_req = 1'b0;
            else    instr_req = 1'b0;
         end
      end
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b0;
      check_quiet("idle_after");
      won_data = wd;
   endtask

   initial begin
      logic w;
      logic [3:0] grants;
      logic [3:0] exp_grants;
      rst_n = 1'b0; instr_req = 1'b0; data_req = 1'b0;
      instr_addr = '0; data_addr = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single fetch, zero-wait slave.
      instr_req = 1'b1; instr_addr = 32'h0000_1004;
      do_txn(0, 0, 32'h0050_0093, 1'b0, w);
      check("t2_winner", {31'd0, w}, 32'd0);

      // Stalled load: 2 AR stall cycles + 3 R stall cycles -> valid in cycle 8.
      data_req = 1'b1; data_addr = 32'h0000_2468;
      do_txn(2, 3, 32'hCAFE_F00D, 1'b0, w);
      check("t3_winner", {31'd0, w}, 32'd1);

      // Address truncation.
      data_req = 1'b1; data_addr = 32'hDEAD_BEEC;
      do_txn(0, 0, 32'h1234_5678, 1'b0, w);
      check("t6_winner", {31'd0, w}, 32'd1);

      // Tie at 0x10 / 0x20.
      instr_req = 1'b1; instr_addr = 32'h10;
      data_req  = 1'b1; data_addr  = 32'h20;
      do_txn(0, 0, 32'hAAAA_0001, 1'b0, w);
`ifdef ARB_ROUND_ROBIN_EN
      check("t4_first", {31'd0, w}, 32'd0);
`else
      check("t4_first", {31'd0, w}, 32'd1);
`endif
      do_txn(0, 0, 32'hAAAA_0002, 1'b0, w);
`ifdef ARB_ROUND_ROBIN_EN
      check("t4_second", {31'd0, w}, 32'd1);
`else
      check("t4_second", {31'd0, w}, 32'd0);
`endif

      // Reset asserted while in S_R aborts the fetch with no valid pulse.
      instr_req = 1'b1; instr_addr = 32'h40;
      @(negedge clk);
      check("rst_ar", {31'd0, arvalid}, 32'd1);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("rst_in_r", {31'd0, rready}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_quiet("rst_mid");
      instr_req = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      rst_n = 1'b1; rvalid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      model_last_data = 1'b1;
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_quiet("post_rst");
      end

      // Both requesters held high for four transactions.
      for (int i = 0; i < 4; i++) begin
         instr_req = 1'b1; instr_addr = 32'h100 + i;
         data_req  = 1'b1; data_addr  = 32'h200 + i;
         do_txn(0, 0, $urandom, 1'b1, w);
         grants[i] = w;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_grants = 4'b1010;   // I,D,I,D in bit order 0..3
`else
      exp_grants = 4'b1111;
`endif
      check("t5_grants", {28'd0, grants}, {28'd0, exp_grants});
      instr_req = 1'b0; data_req = 1'b0;

      // Random traffic: pending requests stay high until served.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) instr_req = 1'b1;
         if ($urandom_range(0, 2) == 0) data_req  = 1'b1;
         instr_addr = $urandom;
         data_addr  = $urandom;
         if (!instr_req && !data_req) begin
            @(negedge clk);
            check_quiet("idle_noreq");
         end else begin
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1, w);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
